riscv_insn_decode: RTL
======================

Name: riscv_insn_decode

Overview:
- Decode stage that sits directly upstream of the instruction execution unit.
- Accepts a 32-bit RISC-V instruction word over a valid/ready handshake and splits it into opcode, funct3, funct7, imm and rd address.
- Reads rs1/rs2 operand values from an internal 32-entry register file and presents all fields in a registered output stage that feeds the execution unit.
- Also owns the register-file write port, driven by writeback, with same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, register and operand width in bits (32 or 64).

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_insn holds a valid instruction
- in_ready  output  1  stage can accept in_insn this cycle
- in_insn  input  32  raw instruction word
- out_valid  output  1  decoded fields below are valid
- out_ready  input  1  execution unit consumes the output this cycle
- opcode  output  7  insn[6:0]
- funct3  output  3  insn[14:12]
- funct7  output  7  insn[31:25]
- imm  output  20  immediate, format per Behaviour
- rs1  output  XLEN  value of register insn[19:15]
- rs2  output  XLEN  value of register insn[24:20]
- rd_addr  output  5  insn[11:7]
- illegal  output  1  opcode is not in the supported set
- wb_en  input  1  write wb_data to register wb_addr
- wb_addr  input  5  writeback register index
- wb_data  input  XLEN  writeback value

Behaviour:
- Reset (reset=1 at a clock edge):
  - out_valid=0.
  - opcode, funct3, funct7, imm, rs1, rs2, rd_addr and illegal all 0.
  - All 32 register-file entries cleared to 0.
  - A writeback presented in the same cycle as reset is dropped.
  - Reset mid-transfer discards the held output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-entry output register).
  - Transfer-in occurs when in_valid && in_ready.
  - Transfer-out occurs when out_valid && out_ready.
  - On transfer-in, all output fields load on that edge and out_valid=1 the next cycle. Latency is 1 cycle.
  - On transfer-out with no transfer-in, out_valid goes to 0.
  - Simultaneous transfer-out and transfer-in: out_valid stays 1 and the fields are replaced. This gives full throughput of one instruction per cycle.
  - While out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Immediate formats (imm is 20 bits):
  - U-type, LUI 0110111 and AUIPC 0010111: insn[31:12].
  - I-type, OP-IMM 0010011, LOAD 0000011, JALR 1100111: sign-extend insn[31:20] to 20 bits.
  - S-type, STORE 0100011: sign-extend {insn[31:25], insn[11:7]}.
  - R-type, OP 0110011: imm=0.
- illegal:
  - illegal=1 for any opcode outside the seven listed above.
  - For an illegal opcode, fields are still loaded, imm=0 and the handshake proceeds normally.
- Register file:
  - 32 x XLEN entries.
  - x0 reads 0 always; writes to x0 are ignored.
  - Write on the clock edge when wb_en=1 and wb_addr!=0. Writes are independent of the handshake and occur even when stalled.
- Operand read:
  - Sampled at transfer-in.
  - If wb_en && wb_addr!=0 && wb_addr==rs1 index in the same cycle, rs1 captures wb_data (bypass); same rule for rs2.
  - Captured operand values are not updated by later writebacks while the output is stalled.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants (OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR).
  - Register index typedef reg_idx_t (5 bits).
  - The execution unit migrates to this package as well.
- Sub-module riscv_regfile:
  - Two combinational read ports, one synchronous write port, x0 hardwiring, synchronous reset clear.
  - Bypass muxing stays in riscv_insn_decode.

Test Plan:
- Reset, then in_valid=1 with in_insn=0x123450B7 (lui x1,0x12345) and out_ready=1 → next cycle out_valid=1, opcode=0110111, imm=0x12345, rd_addr=1, illegal=0.
- Write back wb_en=1, wb_addr=2, wb_data=7; wb_addr=3, wb_data=5; then issue add x4,x2,x3 (0x00310233) → rs1=7, rs2=5, funct7=0, funct3=0.
- In the same cycle as issuing sub x5,x6,x6 (0x406302B3), drive wb_en=1, wb_addr=6, wb_data=9 → rs1=rs2=9, funct7=0100000 (bypass).
- addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFF, rs1=0. A writeback to x0 followed by a read of x0 returns 0.
- Hold out_ready=0 with two back-to-back valid instructions → first output held stable, in_ready=0, second not lost. Raising out_ready gives one transfer per cycle with no bubble.
- Instruction 0x0000007F → illegal=1. Asserting reset while out_valid=1 → out_valid=0 next cycle and all registers read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the decode stage and the execution unit:
// opcode constants, register index type and instruction format classification.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [2:0] {
    FMT_U,
    FMT_I,
    FMT_S,
    FMT_R,
    FMT_BAD
  } insn_fmt_e;

  // Anything outside the supported opcode set classifies as FMT_BAD.
  function automatic insn_fmt_e get_fmt(input logic [6:0] opc);
    insn_fmt_e fmt;
    case (opc)
      OPC_LUI, OPC_AUIPC:           fmt = FMT_U;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                    fmt = FMT_S;
      OPC_OP:                       fmt = FMT_R;
      default:                      fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear on reset.
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  reg_idx_t        i_rd_addr_a,
  output logic [XLEN-1:0] o_rd_data_a,
  input  reg_idx_t        i_rd_addr_b,
  output logic [XLEN-1:0] o_rd_data_b,
  input  logic            i_wr_en,
  input  reg_idx_t        i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [32];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

endmodule

// File: rtl/riscv_insn_decode.sv
// Decode stage: splits an instruction into fields, reads operands with
// writeback bypass, and holds the result in a single-entry output register.
module riscv_insn_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [19:0]     imm,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [4:0]      rd_addr,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic            r_out_valid;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [19:0]     r_imm;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd_addr;
  logic            r_illegal;

  reg_idx_t        w_rs1_idx;
  reg_idx_t        w_rs2_idx;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_wb_live;
  logic            w_fire_in;
  logic [19:0]     w_imm;
  logic            w_illegal;

  assign w_rs1_idx = reg_idx_t'(in_insn[19:15]);
  assign w_rs2_idx = reg_idx_t'(in_insn[24:20]);

  riscv_regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clock       (clock),
    .reset       (reset),
    .i_rd_addr_a (w_rs1_idx),
    .o_rd_data_a (w_rf_rs1),
    .i_rd_addr_b (w_rs2_idx),
    .o_rd_data_b (w_rf_rs2),
    .i_wr_en     (wb_en),
    .i_wr_addr   (reg_idx_t'(wb_addr)),
    .i_wr_data   (wb_data)
  );

  // A writeback landing on this edge must be visible to the instruction sampled on it.
  assign w_wb_live = wb_en && (wb_addr != 5'd0);
  assign w_rs1_val = (w_wb_live && (wb_addr == w_rs1_idx)) ? wb_data : w_rf_rs1;
  assign w_rs2_val = (w_wb_live && (wb_addr == w_rs2_idx)) ? wb_data : w_rf_rs2;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_fire_in = in_valid && in_ready;

  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (get_fmt(in_insn[6:0]))
      FMT_U:   w_imm = in_insn[31:12];
      FMT_I:   w_imm = {{8{in_insn[31]}}, in_insn[31:20]};
      FMT_S:   w_imm = {{8{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      FMT_R:   w_imm = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd_addr   <= '0;
      r_illegal   <= 1'b0;
    end else if (w_fire_in) begin
      r_out_valid <= 1'b1;
      r_opcode    <= in_insn[6:0];
      r_funct3    <= in_insn[14:12];
      r_funct7    <= in_insn[31:25];
      r_imm       <= w_imm;
      r_rs1       <= w_rs1_val;
      r_rs2       <= w_rs2_val;
      r_rd_addr   <= in_insn[11:7];
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign funct3    = r_funct3;
  assign funct7    = r_funct7;
  assign imm       = r_imm;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd_addr   = r_rd_addr;
  assign illegal   = r_illegal;

endmodule
